// File: rtl/lab3_decoder_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : lab3_decoder_rr_arbiter_if
//  Brief    : Request/grant bundle between 32 requesters and the
//             round-robin decoder arbiter.
//  Revision : 1.0
// ============================================================================
interface lab3_decoder_rr_arbiter_if;
    logic [31:0] req;
    logic        rel;      // owner release; "release" is a reserved word
    logic [4:0]  A;
    logic        enable;
    logic [31:0] grant;
    logic        busy;
    logic        timeout;

    modport master (
        output req, rel,
        input  A, enable, grant, busy, timeout
    );

    modport slave (
        input  req, rel,
        output A, enable, grant, busy, timeout
    );
endinterface
`default_nettype wire

// File: rtl/lab3_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lab3_decoder_rr_arbiter
//  Brief    : Round-robin arbiter driving a shared 5x32 decoder, with hold
//             timeout and a one-cycle break-before-make gap between grants.
//  Revision : 1.0
// ============================================================================
module lab3_decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  wire                         clock,
    input  wire                         reset,
    lab3_decoder_rr_arbiter_if.slave    bus
);

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [4:0]         r_a, w_a_nxt;
    logic               r_en, w_en_nxt;
    logic [31:0]        r_grant, w_grant_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [4:0]         r_last, w_last_nxt;

    logic [4:0]         w_winner;
    logic [4:0]         w_idx;
    logic               w_found;
    logic               w_any_req;
    logic               w_owner_req;
    logic               w_at_limit;

    assign w_any_req   = |bus.req;
    assign w_owner_req = bus.req[r_a];
    assign w_at_limit  = (r_cnt == C_HOLD_LAST);

    // Search starts one past the last owner; offset 32 wraps back to the
    // last owner itself, so it only wins when it is the sole requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        w_idx    = r_last;
        for (int i = 1; i <= 32; i++) begin
            w_idx = r_last + 5'(i);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_a_nxt       = r_a;
        w_en_nxt      = r_en;
        w_grant_nxt   = r_grant;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        w_timeout_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_GAP: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_a_nxt     = w_winner;
                    w_en_nxt    = 1'b1;
                    w_grant_nxt = 32'd1 << w_winner;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_en_nxt    = 1'b0;
                    w_grant_nxt = '0;
                end
            end
            S_GRANT: begin
                if (bus.rel || !w_owner_req || w_at_limit) begin
                    w_state_nxt   = S_GAP;
                    w_en_nxt      = 1'b0;
                    w_grant_nxt   = '0;
                    w_last_nxt    = r_a;
                    // Timeout only when the limit was the sole reason to exit
                    w_timeout_nxt = w_at_limit && !bus.rel && w_owner_req;
                end else if (!w_at_limit) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_en_nxt    = 1'b0;
                w_grant_nxt = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_en      <= 1'b0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_last    <= 5'd31;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_en      <= w_en_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
        end
    end

    assign bus.A       = r_a;
    assign bus.enable  = r_en;
    assign bus.grant   = r_grant;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_lab3_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab3_decoder_rr_arbiter
//  Brief    : Directed self-checking bench for the round-robin decoder arbiter.
//  Revision : 1.0
// ============================================================================
module tb_lab3_decoder_rr_arbiter;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    lab3_decoder_rr_arbiter_if bus ();

    lab3_decoder_rr_arbiter #(
        .MAX_HOLD (16),
        .CNT_W    (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [4:0] a, input logic en,
                              input logic bsy, input logic to);
        logic [31:0] g;
        g = en ? (32'd1 << a) : 32'd0;
        chk({tag, ".A"},       32'(bus.A),       32'(a));
        chk({tag, ".enable"},  32'(bus.enable),  32'(en));
        chk({tag, ".grant"},   bus.grant,        g);
        chk({tag, ".busy"},    32'(bus.busy),    32'(bsy));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(to));
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        #2 reset = 1'b1;
        bus.req = '0;
        bus.rel = 1'b0;
        tick;
        #2 reset = 1'b0;
        tick;
    endtask

    logic [4:0] rr_order [5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bus.req  = '0;
        bus.rel  = 1'b0;
        #2;
        expect_out("reset_async", 5'd0, 1'b0, 1'b0, 1'b0);
        tick;
        #2 reset = 1'b0;
        tick;
        expect_out("reset_idle", 5'd0, 1'b0, 1'b0, 1'b0);

        // 1: sole requester 0, release during third grant cycle
        bus.req = 32'h0000_0001;
        tick; expect_out("t1_g1", 5'd0, 1'b1, 1'b1, 1'b0);
        tick; expect_out("t1_g2", 5'd0, 1'b1, 1'b1, 1'b0);
        tick; expect_out("t1_g3", 5'd0, 1'b1, 1'b1, 1'b0);
        bus.rel = 1'b1;
        tick; expect_out("t1_gap", 5'd0, 1'b0, 1'b1, 1'b0);
        bus.rel = 1'b0;
        tick; expect_out("t1_regrant", 5'd0, 1'b1, 1'b1, 1'b0);
        bus.req = '0;
        tick; expect_out("t1_drop_gap", 5'd0, 1'b0, 1'b1, 1'b0);
        tick; expect_out("t1_idle", 5'd0, 1'b0, 1'b0, 1'b0);

        // 2: wrap-around order 0,1,31,0,1 from a fresh pointer
        do_reset;
        rr_order[0] = 5'd0;  rr_order[1] = 5'd1; rr_order[2] = 5'd31;
        rr_order[3] = 5'd0;  rr_order[4] = 5'd1;
        bus.req = 32'h8000_0003;
        for (int g = 0; g < 5; g++) begin
            tick; expect_out($sformatf("t2_grant%0d", g), rr_order[g], 1'b1, 1'b1, 1'b0);
            tick; expect_out($sformatf("t2_hold%0d", g), rr_order[g], 1'b1, 1'b1, 1'b0);
            bus.rel = 1'b1;
            tick; expect_out($sformatf("t2_gap%0d", g), rr_order[g], 1'b0, 1'b1, 1'b0);
            bus.rel = 1'b0;
        end
        bus.req = '0;
        tick; expect_out("t2_idle", 5'd1, 1'b0, 1'b0, 1'b0);

        // 3: hold limit on requester 4 -> 16 grant cycles then timeout
        do_reset;
        bus.req = 32'h0000_0010;
        for (int c = 1; c <= 16; c++) begin
            tick; expect_out($sformatf("t3_c%0d", c), 5'd4, 1'b1, 1'b1, 1'b0);
        end
        tick; expect_out("t3_timeout", 5'd4, 1'b0, 1'b1, 1'b1);
        tick; expect_out("t3_regrant", 5'd4, 1'b1, 1'b1, 1'b0);

        // 4: release coincides with the limit -> no timeout pulse
        for (int c = 2; c <= 16; c++) begin
            tick;
        end
        expect_out("t4_c16", 5'd4, 1'b1, 1'b1, 1'b0);
        bus.rel = 1'b1;
        tick; expect_out("t4_exit", 5'd4, 1'b0, 1'b1, 1'b0);
        bus.rel = 1'b0;
        bus.req = '0;
        tick; expect_out("t4_idle", 5'd4, 1'b0, 1'b0, 1'b0);

        // 5: owner 5 drops its request, requester 9 takes over
        do_reset;
        bus.req = 32'h0000_0220;
        tick; expect_out("t5_g5", 5'd5, 1'b1, 1'b1, 1'b0);
        tick; expect_out("t5_g5b", 5'd5, 1'b1, 1'b1, 1'b0);
        bus.req = 32'h0000_0200;
        tick; expect_out("t5_gap", 5'd5, 1'b0, 1'b1, 1'b0);
        tick; expect_out("t5_g9", 5'd9, 1'b1, 1'b1, 1'b0);
        chk("t5_grant_word", bus.grant, 32'h0000_0200);

        // 6: async reset mid-grant, then search restarts at 0
        #2 reset = 1'b1;
        #1; expect_out("t6_async", 5'd0, 1'b0, 1'b0, 1'b0);
        bus.req = 32'h0000_0004;
        #2 reset = 1'b0;
        tick; expect_out("t6_g2", 5'd2, 1'b1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
